uart_transmitter_fifo: RTL and testbench

//  Serialises bytes onto the UART tx line as 8N1 (or 8N2) frames, LSB first.

---
 rtl/uart_transmitter_fifo.sv | 192 +++++++++++++++++++
 tb/tb_uart_transmitter_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter_fifo.sv
// rtl/uart_transmitter_fifo.sv - 8N1/8N2 UART transmitter fed by a small byte FIFO
module uart_transmitter_fifo #(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_AW    = 2
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       clken,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       busy,
    output logic       tx
);

    localparam int                 DEPTH     = 1 << FIFO_AW;
    localparam int                 CNT_W     = FIFO_AW + 1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [3:0]         TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]         STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_tick;
    logic [2:0]         r_bitpos;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_next;
    logic [3:0]         w_tick_next;
    logic [2:0]         w_bitpos_next;
    logic [7:0]         w_shift_next;
    logic               w_tx_next;

    // full is the registered flag, so a write while full is dropped even if a pop happens this cycle
    assign w_push = wr_en && !r_full;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CNT_ONE;
        else if (!w_push && w_pop)
            w_count_next = r_count - CNT_ONE;
    end

    always_ff @(posedge clk_50m) begin
        if (w_push)
            r_mem[r_wptr] <= din;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)
                r_rptr <= r_rptr + PTR_ONE;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_FULL);
            r_empty <= (w_count_next == '0);
            if (wr_en && r_full)
                r_overflow <= 1'b1;
            else if (ovf_clr)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (clken) begin
            case (r_state)
                S_IDLE:  if (!r_empty) w_state_next = S_START;
                S_START: if (r_tick == TICK_LAST) w_state_next = S_DATA;
                S_DATA:  if (r_tick == TICK_LAST && r_bitpos == 3'd7) w_state_next = S_STOP;
                S_STOP:  if (r_tick == TICK_LAST && r_bitpos == STOP_LAST) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // In STOP, bitpos counts completed stop bits so 8N2 needs no wider tick counter
    always_comb begin
        w_pop         = 1'b0;
        w_tick_next   = r_tick;
        w_bitpos_next = r_bitpos;
        w_shift_next  = r_shift;
        w_tx_next     = r_tx;
        if (clken) begin
            case (r_state)
                S_IDLE: begin
                    w_tx_next = 1'b1;
                    if (!r_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rptr];
                        w_tx_next    = 1'b0;
                        w_tick_next  = '0;
                    end
                end
                S_START: begin
                    if (r_tick == TICK_LAST) begin
                        w_tx_next     = r_shift[0];
                        w_bitpos_next = '0;
                        w_tick_next   = '0;
                    end else begin
                        w_tick_next = r_tick + 4'd1;
                    end
                end
                S_DATA: begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_next = '0;
                        if (r_bitpos == 3'd7) begin
                            w_tx_next     = 1'b1;
                            w_bitpos_next = '0;
                        end else begin
                            w_shift_next  = r_shift >> 1;
                            w_tx_next     = r_shift[1];
                            w_bitpos_next = r_bitpos + 3'd1;
                        end
                    end else begin
                        w_tick_next = r_tick + 4'd1;
                    end
                end
                S_STOP: begin
                    w_tx_next = 1'b1;
                    if (r_tick == TICK_LAST) begin
                        w_tick_next   = '0;
                        w_bitpos_next = (r_bitpos == STOP_LAST) ? 3'd0 : r_bitpos + 3'd1;
                    end else begin
                        w_tick_next = r_tick + 4'd1;
                    end
                end
                default: begin
                    w_tx_next     = 1'b1;
                    w_tick_next   = '0;
                    w_bitpos_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_tx     <= 1'b1;
            r_tick   <= '0;
            r_bitpos <= '0;
            r_shift  <= '0;
        end else begin
            r_tx     <= w_tx_next;
            r_tick   <= w_tick_next;
            r_bitpos <= w_bitpos_next;
            r_shift  <= w_shift_next;
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign overflow = r_overflow;
    assign busy     = (r_state != S_IDLE);
    assign tx       = r_tx;

endmodule

// File: tb/tb_uart_transmitter_fifo.sv
// tb/tb_uart_transmitter_fifo.sv - directed self-checking bench for uart_transmitter_fifo
module tb_uart_transmitter_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clken;
    logic [7:0] din;
    logic       wr_a;
    logic       wr_b;
    logic       ovf_clr;
    logic       full_a, empty_a, ovf_a, busy_a, tx_a;
    logic       full_b, empty_b, ovf_b, busy_b, tx_b;

    int n_checks = 0;
    int n_errors = 0;
    int tick_cnt = 0;
    bit clken_en = 1'b1;
    bit sel      = 1'b0;

    uart_transmitter_fifo #(.OVERSAMPLE(16), .STOP_BITS(1), .FIFO_AW(2)) u_dut_a (
        .clk_50m(clk), .rst_n(rst_n), .clken(clken), .din(din), .wr_en(wr_a),
        .full(full_a), .empty(empty_a), .overflow(ovf_a), .ovf_clr(ovf_clr),
        .busy(busy_a), .tx(tx_a)
    );

    uart_transmitter_fifo #(.OVERSAMPLE(16), .STOP_BITS(2), .FIFO_AW(2)) u_dut_b (
        .clk_50m(clk), .rst_n(rst_n), .clken(clken), .din(din), .wr_en(wr_b),
        .full(full_b), .empty(empty_b), .overflow(ovf_b), .ovf_clr(ovf_clr),
        .busy(busy_b), .tx(tx_b)
    );

    wire txs   = sel ? tx_b   : tx_a;
    wire busys = sel ? busy_b : busy_a;

    always #10 clk = ~clk;

    always @(posedge clk) if (clken) tick_cnt <= tick_cnt + 1;

    initial begin
        clken = 1'b0;
        forever begin
            repeat (26) @(negedge clk);
            clken = clken_en;
            @(negedge clk);
            clken = 1'b0;
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (!clken);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        din  = d;
        wr_a = !sel;
        wr_b = sel;
    endtask

    task automatic wr_done();
        @(negedge clk);
        wr_a = 1'b0;
        wr_b = 1'b0;
        din  = ~din;
    endtask

    // Mid-bit sampling from the start edge; returns data, start tick and ticks until busy drops
    task automatic rx_frame(input int limit, output logic [7:0] d, output bit found,
                            output int start_t, output int busy_len, output bit stop_ok);
        found = 1'b0; d = '0; start_t = 0; busy_len = 0; stop_ok = 1'b1;
        for (int i = 0; i < limit && !found; i++) begin
            wait_tick();
            if (txs == 1'b0) found = 1'b1;
        end
        if (!found) return;
        start_t = tick_cnt;
        repeat (8) wait_tick();
        check("start_bit", txs, 0);
        for (int b = 0; b < 8; b++) begin
            repeat (16) wait_tick();
            d[b] = txs;
        end
        repeat (16) wait_tick();
        if (txs !== 1'b1) stop_ok = 1'b0;
        for (int i = 0; i < 100 && busys; i++) begin
            wait_tick();
            if (txs !== 1'b1) stop_ok = 1'b0;
        end
        busy_len = tick_cnt - start_t;
    endtask

    logic [7:0] d0, d1, d2, d3;
    bit         f0, f1, f2, f3, s0, s1, s2, s3;
    int         t0, t1, t2, t3, b0, b1, b2, b3;
    logic [7:0] exp4 [4] = '{8'h10, 8'h20, 8'h30, 8'h40};

    initial begin
        rst_n = 1'b0; din = '0; wr_a = 1'b0; wr_b = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_full", full_a, 0);
        check("rst_empty", empty_a, 1);
        check("rst_ovf", ovf_a, 0);

        // single 0x55 frame
        wait_tick();
        wr(8'h55); wr_done();
        rx_frame(100, d0, f0, t0, b0, s0);
        check("t1_found", f0, 1);
        check("t1_data", d0, 8'h55);
        check("t1_busy_len", b0, 160);
        check("t1_stop", s0, 1);
        check("t1_empty", empty_a, 1);

        // three queued frames, back to back
        wait_tick();
        wr(8'h00); wr(8'hFF); wr(8'hA3); wr_done();
        rx_frame(100, d0, f0, t0, b0, s0);
        rx_frame(100, d1, f1, t1, b1, s1);
        rx_frame(100, d2, f2, t2, b2, s2);
        check("t2_data0", d0, 8'h00);
        check("t2_data1", d1, 8'hFF);
        check("t2_data2", d2, 8'hA3);
        check("t2_period01", t1 - t0, 161);
        check("t2_period12", t2 - t1, 161);

        // fill with clken frozen, overflow on the fifth write
        wait_tick();
        clken_en = 1'b0;
        for (int i = 0; i < 4; i++) wr(exp4[i]);
        wr_done();
        check("t3_full", full_a, 1);
        check("t3_empty", empty_a, 0);
        check("t3_ovf_before", ovf_a, 0);
        check("t3_frozen_busy", busy_a, 0);
        wr(8'h50); wr_done();
        check("t3_ovf_set", ovf_a, 1);
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        check("t3_ovf_clr", ovf_a, 0);
        @(negedge clk); din = 8'h60; wr_a = 1'b1; ovf_clr = 1'b1;
        @(negedge clk); wr_a = 1'b0; ovf_clr = 1'b0;
        check("t3_set_wins", ovf_a, 1);
        check("t3_tx_idle", tx_a, 1);
        clken_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_frame(100, d0, f0, t0, b0, s0);
            check("t3_found", f0, 1);
            check("t3_data", d0, exp4[i]);
        end
        rx_frame(200, d0, f0, t0, b0, s0);
        check("t3_no_fifth", f0, 0);

        // inter-frame gap of exactly one tick
        wait_tick();
        wr(8'h12); wr(8'h34); wr_done();
        rx_frame(100, d0, f0, t0, b0, s0);
        rx_frame(100, d1, f1, t1, b1, s1);
        check("t4_data0", d0, 8'h12);
        check("t4_data1", d1, 8'h34);
        check("t4_gap", t1 - (t0 + b0), 1);

        // async reset during bit 3
        wait_tick();
        wr(8'hF0); wr(8'h0F); wr_done();
        f3 = 1'b0;
        for (int i = 0; i < 100 && !f3; i++) begin
            wait_tick();
            if (tx_a == 1'b0) f3 = 1'b1;
        end
        check("t5_found", f3, 1);
        repeat (72) wait_tick();
        check("t5_bit3", tx_a, 0);
        @(posedge clk); #5;
        rst_n = 1'b0;
        #2;
        check("t5_async_tx", tx_a, 1);
        check("t5_async_busy", busy_a, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("t5_empty", empty_a, 1);
        rx_frame(200, d0, f0, t0, b0, s0);
        check("t5_no_frame", f0, 0);

        // two stop bits on the second instance
        sel = 1'b1;
        wait_tick();
        wr(8'h81); wr_done();
        rx_frame(100, d0, f0, t0, b0, s0);
        check("t6_found", f0, 1);
        check("t6_data", d0, 8'h81);
        check("t6_busy_len", b0, 176);
        check("t6_stop", s0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
